// File: rtl/ymem_row_fetch.sv
// ymem_row_fetch: fetches one 4-slot Y-matrix row from yMem (four 64-bit
// reads at base = row*4) and presents it as a 256-bit word with a one-cycle
// dataReady pulse. Out-of-range rows pulse row_err and issue no reads.
// Optional macro YMEM_LAST_ROW_CACHE_EN: a repeat request for the most
// recently completed row skips the reads and goes straight to ready.
module ymem_row_fetch #(
  parameter int NUM_ROWS = 64,
  parameter int RD_LAT   = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  input  logic [15:0]  req_row,
  output logic         mem_rd_en,
  output logic [15:0]  mem_addr,
  input  logic [63:0]  mem_rdata,
  output logic [255:0] ymem_data,
  output logic         dataReady,
  output logic         busy,
  output logic         row_err
);

  typedef enum logic [1:0] {IDLE, RD, WAIT, RDY} state_t;

  localparam logic [16:0] ROWS_L = 17'(NUM_ROWS);

  state_t                  r_state, w_next;
  logic [1:0]              r_k;
  logic [15:0]             r_addr;
  logic [RD_LAT:1]         r_rd_pipe;
  logic [RD_LAT:1][1:0]    r_slot_pipe;
  logic [3:0][63:0]        r_slots;
  logic                    r_dready, r_err;
  logic                    w_req_bad, w_hit, w_start;

  assign w_req_bad = req_valid && ({1'b0, req_row} >= ROWS_L);
  assign w_start   = (r_state == IDLE) && req_valid && !w_req_bad && !w_hit;

`ifdef YMEM_LAST_ROW_CACHE_EN
  logic [15:0] r_row, r_cache_row;
  logic        r_cache_vld;

  assign w_hit = r_cache_vld && (r_cache_row == req_row);

  // Remember the row of the fetch in flight; publish it once slot3 lands.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_row       <= '0;
      r_cache_row <= '0;
      r_cache_vld <= 1'b0;
    end else begin
      if (w_start) r_row <= req_row;
      if (r_state == WAIT) begin
        r_cache_row <= r_row;
        r_cache_vld <= 1'b1;
      end
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state plus the state-decoded outputs.
  always_comb begin
    w_next    = r_state;
    mem_rd_en = 1'b0;
    busy      = (r_state != IDLE);
    case (r_state)
      IDLE: if (req_valid && !w_req_bad) w_next = w_hit ? RDY : RD;
      RD: begin
        mem_rd_en = 1'b1;
        if (r_k == 2'd3) w_next = WAIT;
      end
      WAIT:    w_next = RDY;
      RDY:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Address/slot sequencing, delayed capture strobe and registered pulses.
  // The strobe pipe carries the slot index alongside so each read lands in
  // the slot that issued it, RD_LAT cycles later; after reset any data still
  // returning from an abandoned fetch finds an empty pipe and is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_k         <= '0;
      r_addr      <= '0;
      r_rd_pipe   <= '0;
      r_slot_pipe <= '0;
      r_slots     <= '0;
      r_dready    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_dready <= (r_state == RDY);
      r_err    <= (r_state == IDLE) && w_req_bad;
      if (w_start) begin
        r_addr <= {req_row[13:0], 2'b00};
        r_k    <= '0;
      end else if (r_state == RD) begin
        r_k <= r_k + 2'd1;
        if (r_k != 2'd3) r_addr <= r_addr + 16'd1;
      end
      r_rd_pipe[1]   <= mem_rd_en;
      r_slot_pipe[1] <= r_k;
      for (int i = 2; i <= RD_LAT; i++) begin
        r_rd_pipe[i]   <= r_rd_pipe[i-1];
        r_slot_pipe[i] <= r_slot_pipe[i-1];
      end
      // slot0 sits in the top 64 bits, so slot k maps to index 3-k.
      if (r_rd_pipe[RD_LAT]) r_slots[2'd3 - r_slot_pipe[RD_LAT]] <= mem_rdata;
    end
  end

  assign mem_addr  = r_addr;
  assign ymem_data = r_slots;
  assign dataReady = r_dready;
  assign row_err   = r_err;

endmodule

// File: doc/ymem_row_fetch.md
YMEM_ROW_FETCH -- requirements
Module: ymem_row_fetch

Interface
REQ-001 Parameter: NUM_ROWS, default 64, number of Y-matrix rows held in yMem; legal range 1..16384.
REQ-002 Parameter: RD_LAT, default 1, yMem read latency in cycles; fixed at 1 in this revision.
REQ-003 clock  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  one-cycle fetch request from the Y filter stage.
REQ-006 req_row  input  16  row index to fetch; sampled with req_valid.
REQ-007 mem_rd_en  output  1  yMem read strobe.
REQ-008 mem_addr  output  16  yMem word address.
REQ-009 mem_rdata  input  64  yMem read data, valid RD_LAT cycles after mem_rd_en.
REQ-010 ymem_data  output  256  assembled row: slot0 [255:192], slot1 [191:128], slot2 [127:64], slot3 [63:0]; each slot is {col[15:0], real[23:0], img[23:0]}.
REQ-011 dataReady  output  1  one-cycle pulse; ymem_data is valid and remains held until the next fetch starts.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 row_err  output  1  one-cycle pulse when req_row >= NUM_ROWS.

Function
REQ-014 The FSM SHALL have four states: IDLE, RD, WAIT, RDY.
REQ-015 IDLE + req_valid + req_row < NUM_ROWS -> RD; latch row; base = req_row<<2; clear slot counter.
REQ-016 IDLE + req_valid + req_row >= NUM_ROWS -> pulse row_err next cycle; stay IDLE; issue no reads; ymem_data unchanged.
REQ-017 RD SHALL last exactly 4 cycles: mem_rd_en=1, mem_addr = base+k for k=0,1,2,3; then -> WAIT.
REQ-018 A delayed read strobe plus slot index SHALL capture mem_rdata into slot k one cycle after read k issues.
REQ-019 WAIT SHALL last 1 cycle and capture slot3; then -> RDY.
REQ-020 RDY SHALL last 1 cycle with dataReady=1; then -> IDLE.
REQ-021 Miss latency: req_valid sampled at edge N -> dataReady high in the cycle after edge N+6.
REQ-022 req_valid outside IDLE (busy=1) SHALL be ignored; no queueing; the requester retries.
REQ-023 mem_rd_en SHALL be 0 in IDLE, WAIT and RDY; mem_addr SHALL hold its last value when mem_rd_en=0.
REQ-024 Slot contents SHALL pass through unmodified; diagonal-marker bits (col[15:13]) are not interpreted here.
REQ-025 ymem_data SHALL change only during capture cycles of an accepted fetch.

Reset
REQ-026 Reset SHALL force IDLE, mem_rd_en=0, mem_addr=0, ymem_data=0, dataReady=0, busy=0, row_err=0, and the slot counter to 0.
REQ-027 Reset mid-fetch SHALL abandon the fetch; no dataReady follows; rdata returned after reset SHALL be discarded.
REQ-028 Reset SHALL invalidate the last-row cache (see REQ-030).

Configuration
REQ-029 The macro YMEM_LAST_ROW_CACHE_EN SHALL select last-row caching.
REQ-030 Defined: after each completed fetch, store the row index and set cache_vld. IDLE + req_valid + req_row == cached row + cache_vld -> go directly to RDY; no reads; dataReady high in the cycle after edge N+1; ymem_data unchanged.
REQ-031 Not defined: every valid request performs the full 4-read fetch; no cache state is synthesised.

Verification
REQ-032 Fetch row 3 with mem returning 64'hA..D pattern -> reads at addr 12,13,14,15 on consecutive cycles; dataReady at N+7; ymem_data = {D0,D1,D2,D3} in slot order.
REQ-033 req_row=64 with NUM_ROWS=64 -> row_err one pulse; mem_rd_en stays 0; busy stays 0.
REQ-034 Second req_valid at N+2 during row-3 fetch -> ignored; only 4 reads occur; single dataReady.
REQ-035 Reset asserted on the 3rd RD cycle -> all outputs 0 next cycle; no dataReady; a new fetch of row 5 then completes normally at addr 20..23.
REQ-036 With YMEM_LAST_ROW_CACHE_EN: fetch row 7 twice -> second request makes zero reads and dataReady 2 cycles later; after reset, a row-7 request performs the full fetch.
REQ-037 Back-to-back: req row 1, then req row 2 on the cycle after dataReady -> accepted; reads at addr 8..11.
